// File: rtl/text_overlay_pkg.sv
// Shared constants and types for the text overlay renderer.
// Glyph geometry, the clear fill value and the control FSM states live here.
package text_overlay_pkg;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;

  localparam logic [5:0] SPACE_CODE = 6'd37;

  localparam int ATTR_BLINK = 6;
  localparam int ATTR_INV   = 7;

  localparam logic [7:0] CLEAR_CELL = {2'b00, SPACE_CODE};

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

endpackage

// File: rtl/ascii_rom.sv
// Glyph ROM: 64 codes x 16 rows x 8 pixels, addressed as {code, glyph_row}.
// Purely combinational; callers register the result. Bit 7 is the leftmost pixel.
module ascii_rom (
  input  logic [9:0] addr_i,
  output logic [7:0] data_o
);

  always_comb begin
    data_o = 8'h00;
    case (addr_i)
      {6'd11, 4'd0}:  data_o = 8'h18;
      {6'd11, 4'd1}:  data_o = 8'h3C;
      {6'd11, 4'd2}:  data_o = 8'h66;
      {6'd11, 4'd3}:  data_o = 8'h66;
      {6'd11, 4'd4}:  data_o = 8'h66;
      {6'd11, 4'd5}:  data_o = 8'h7E;
      {6'd11, 4'd6}:  data_o = 8'h7E;
      {6'd11, 4'd7}:  data_o = 8'h66;
      {6'd11, 4'd8}:  data_o = 8'h66;
      {6'd11, 4'd9}:  data_o = 8'h66;
      {6'd11, 4'd10}: data_o = 8'h66;
      {6'd11, 4'd11}: data_o = 8'h66;
      {6'd12, 4'd0}:  data_o = 8'h7C;
      {6'd12, 4'd1}:  data_o = 8'h66;
      {6'd12, 4'd2}:  data_o = 8'h66;
      {6'd12, 4'd3}:  data_o = 8'h66;
      {6'd12, 4'd4}:  data_o = 8'h7C;
      {6'd12, 4'd5}:  data_o = 8'h7C;
      {6'd12, 4'd6}:  data_o = 8'h66;
      {6'd12, 4'd7}:  data_o = 8'h66;
      {6'd12, 4'd8}:  data_o = 8'h66;
      {6'd12, 4'd9}:  data_o = 8'h66;
      {6'd12, 4'd10}: data_o = 8'h7C;
      default:        data_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/text_overlay_buf.sv
// Single-port character cell buffer with synchronous read and write.
// A write claims the shared address; the read data that cycle is the old cell contents.
module text_overlay_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [AW-1:0] raddr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    rdata_q;
  logic [AW-1:0] addr;

  assign addr    = we_i ? waddr_i : raddr_i;
  assign rdata_o = rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr] <= wdata_i;
    end
    rdata_q <= mem_q[addr];
  end

endmodule

// File: rtl/text_overlay.sv
// Writable ROWS x COLS text window with pixel scaling and blink/inverse attributes.
// Two-stage pixel pipeline: cell buffer read, then glyph lookup and colour select.
module text_overlay
  import text_overlay_pkg::*;
#(
  parameter int                    COLOR_BITS     = 24,
  parameter int                    COLS           = 16,
  parameter int                    ROWS           = 4,
  parameter int                    SCALE_LOG2     = 1,
  parameter int                    ORIGIN_X       = 64,
  parameter int                    ORIGIN_Y       = 128,
  parameter logic [COLOR_BITS-1:0] FG_COLOR       = 24'h000000,
  parameter logic [COLOR_BITS-1:0] BG_COLOR       = 24'hE0E0E0,
  parameter int                    BLINK_LOG2     = 5,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  localparam int                   CELLS          = ROWS * COLS,
  localparam int                   AW             = (CELLS > 1) ? $clog2(CELLS) : 1,
  localparam int                   CB             = COLOR_BITS / 3
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [9:0]    hpos_i,
  input  logic [9:0]    vpos_i,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic          clear_i,
  output logic          busy_o,
  output logic          wr_err_o,
  output logic          active_o,
  output logic [CB-1:0] menu_blue_o,
  output logic [CB-1:0] menu_green_o,
  output logic [CB-1:0] menu_red_o
);

  localparam int WIN_W = (COLS * GLYPH_W) << SCALE_LOG2;
  localparam int WIN_H = (ROWS * GLYPH_H) << SCALE_LOG2;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;

  logic [9:0]    dx, dy, col, row;
  logic          in_win;
  logic [AW-1:0] rd_addr;
  logic [3:0]    grow;
  logic [2:0]    bit_idx;

  logic          accept, in_range;
  logic          buf_we;
  logic [AW-1:0] buf_waddr;
  logic [7:0]    buf_wdata;
  logic [7:0]    cell_rd;

  logic [BLINK_LOG2:0]   blink_q, blink_d;
  logic                  wr_err_q, wr_err_d;
  logic [3:0]            s1_grow_q, s1_grow_d;
  logic [2:0]            s1_bit_q, s1_bit_d;
  logic                  s1_win_q, s1_win_d;
  logic [COLOR_BITS-1:0] colour_q, colour_d;
  logic                  active_q, active_d;

  logic [9:0] rom_addr;
  logic [7:0] rom_data;
  logic       pix_on;

  // Window test and cell/glyph coordinates for the current beam position
  always_comb begin
    dx      = hpos_i - 10'(ORIGIN_X);
    dy      = vpos_i - 10'(ORIGIN_Y);
    in_win  = (int'(hpos_i) >= ORIGIN_X) && (int'(dx) < WIN_W) &&
              (int'(vpos_i) >= ORIGIN_Y) && (int'(dy) < WIN_H);
    col     = dx >> (3 + SCALE_LOG2);
    row     = dy >> (4 + SCALE_LOG2);
    rd_addr = in_win ? (AW'(row) * AW'(COLS) + AW'(col)) : '0;
    grow    = dy[SCALE_LOG2 +: 4];
    bit_idx = ~dx[SCALE_LOG2 +: 3];
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_i) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_idx_q == AW'(CELLS - 1)) begin
          state_d   = ST_IDLE;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Writes are only granted while the pipeline is not reading the single buffer port
  always_comb begin
    busy_o     = (state_q == ST_CLEAR);
    wr_ready_o = (state_q == ST_IDLE) && !clear_i && !in_win;
    accept     = wr_valid_i && wr_ready_o;
    in_range   = int'(wr_addr_i) < CELLS;
    buf_we     = 1'b0;
    buf_waddr  = wr_addr_i;
    buf_wdata  = wr_data_i;
    if (busy_o) begin
      buf_we    = 1'b1;
      buf_waddr = clr_idx_q;
      buf_wdata = CLEAR_CELL;
    end else if (accept && in_range) begin
      buf_we = 1'b1;
    end
  end

  text_overlay_buf #(
    .DEPTH (CELLS),
    .AW    (AW)
  ) u_buf (
    .clk_i   (clk_i),
    .we_i    (buf_we),
    .waddr_i (buf_waddr),
    .raddr_i (rd_addr),
    .wdata_i (buf_wdata),
    .rdata_o (cell_rd)
  );

  assign rom_addr = {cell_rd[5:0], s1_grow_q};

  ascii_rom u_rom (
    .addr_i (rom_addr),
    .data_o (rom_data)
  );

  always_comb begin
    blink_d   = blink_q + ((hpos_i == 10'd0 && vpos_i == 10'd0) ? 1'b1 : 1'b0);
    wr_err_d  = wr_err_q | (accept && !in_range);
    s1_grow_d = grow;
    s1_bit_d  = bit_idx;
    s1_win_d  = in_win;

    pix_on = rom_data[s1_bit_q];
    if (cell_rd[ATTR_BLINK] && blink_q[BLINK_LOG2]) begin
      pix_on = 1'b0;
    end
    if (cell_rd[ATTR_INV]) begin
      pix_on = !pix_on;
    end
    colour_d = (s1_win_q && pix_on) ? FG_COLOR : BG_COLOR;
    active_d = s1_win_q;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      blink_q   <= '0;
      wr_err_q  <= 1'b0;
      s1_grow_q <= '0;
      s1_bit_q  <= '0;
      s1_win_q  <= 1'b0;
      colour_q  <= '0;
      active_q  <= 1'b0;
    end else begin
      blink_q   <= blink_d;
      wr_err_q  <= wr_err_d;
      s1_grow_q <= s1_grow_d;
      s1_bit_q  <= s1_bit_d;
      s1_win_q  <= s1_win_d;
      colour_q  <= colour_d;
      active_q  <= active_d;
    end
  end

  assign wr_err_o     = wr_err_q;
  assign active_o     = active_q;
  assign menu_blue_o  = colour_q[3*CB-1:2*CB];
  assign menu_green_o = colour_q[2*CB-1:CB];
  assign menu_red_o   = colour_q[CB-1:0];

endmodule

// File: tb/tb_text_overlay.sv
// Directed bench for text_overlay: 2x4 window at (16,32), unscaled, plus a 3x3
// instance whose 9-cell buffer leaves room for an out-of-range write address.
module tb_text_overlay;

  localparam logic [23:0] FG     = 24'h000000;
  localparam logic [23:0] BG     = 24'hE0E0E0;
  localparam logic [9:0]  IDLE_H = 10'd700;
  localparam logic [9:0]  IDLE_V = 10'd500;

  logic       clk;
  logic       reset_n;
  logic [9:0] hpos, vpos;
  logic       clear;

  logic       wr_valid, wr_ready;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy, wr_err, active;
  logic [7:0] blue, green, red;

  logic       e_valid, e_ready;
  logic [3:0] e_addr;
  logic [7:0] e_data;
  logic       e_busy, e_err, e_active;
  logic [7:0] e_blue, e_green, e_red;

  int n_cmp;
  int n_err;
  logic [7:0] a_row0;

  text_overlay #(
    .COLOR_BITS(24), .COLS(4), .ROWS(2), .SCALE_LOG2(0),
    .ORIGIN_X(16), .ORIGIN_Y(32), .FG_COLOR(24'h000000), .BG_COLOR(24'hE0E0E0),
    .BLINK_LOG2(5), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk_i(clk), .reset_i(reset_n), .hpos_i(hpos), .vpos_i(vpos),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .clear_i(clear), .busy_o(busy), .wr_err_o(wr_err),
    .active_o(active), .menu_blue_o(blue), .menu_green_o(green), .menu_red_o(red)
  );

  text_overlay #(
    .COLOR_BITS(24), .COLS(3), .ROWS(3), .SCALE_LOG2(0),
    .ORIGIN_X(16), .ORIGIN_Y(32), .FG_COLOR(24'h000000), .BG_COLOR(24'hE0E0E0),
    .BLINK_LOG2(5), .CLEAR_ON_RESET(1'b1)
  ) dut_err (
    .clk_i(clk), .reset_i(reset_n), .hpos_i(hpos), .vpos_i(vpos),
    .wr_valid_i(e_valid), .wr_ready_o(e_ready), .wr_addr_i(e_addr),
    .wr_data_i(e_data), .clear_i(clear), .busy_o(e_busy), .wr_err_o(e_err),
    .active_o(e_active), .menu_blue_o(e_blue), .menu_green_o(e_green), .menu_red_o(e_red)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic idle_pos();
    hpos = IDLE_H;
    vpos = IDLE_V;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    bit ok;
    ok       = 1'b0;
    wr_addr  = a;
    wr_data  = d;
    wr_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (wr_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("[TB] FAIL write_accept: ready=%b after 50 cycles, want 1", wr_ready);
    end
  endtask

  task automatic test_reset();
    int cnt;
    repeat (3) @(posedge clk);
    #1;
    hpos = 10'd20;
    vpos = 10'd40;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({blue, green, red} !== 24'h0) begin
      n_err++;
      $display("[TB] FAIL reset_colour: got %h want %h", {blue, green, red}, 24'h0);
    end
    n_cmp++;
    if (active !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_active: got %b want 0", active);
    end
    n_cmp++;
    if (wr_err !== 1'b0 || e_err !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_wr_err: got %b/%b want 0/0", wr_err, e_err);
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL reset_busy: got %b want 1", busy);
    end
    idle_pos();
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy !== 1'b1) break;
      cnt++;
      @(negedge clk);
    end
    n_cmp++;
    if (cnt != 8) begin
      n_err++;
      $display("[TB] FAIL clear_length: busy for %0d cycles, want 8", cnt);
    end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (wr_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL ready_after_clear: got %b want 1", wr_ready);
    end
    // Every cell must now hold a blank space: the whole window renders as background
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i <= 32; i++) begin
        if (i < 32) begin
          hpos = 10'(16 + i);
          vpos = 10'(32 + 16 * r);
        end else begin
          idle_pos();
        end
        @(posedge clk);
        #1;
        if (i >= 1) begin
          n_cmp++;
          if ({blue, green, red} !== BG || active !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL cleared_cell: row %0d h %0d got %h/%b want %h/1",
                     r, 16 + i - 1, {blue, green, red}, active, BG);
          end
        end
      end
    end
  endtask

  task automatic test_pixel_scan();
    logic [23:0] exp_col;
    logic        exp_act;
    int          h;
    do_write(3'd1, 8'h0B);
    for (int i = 0; i <= 40; i++) begin
      if (i < 40) begin
        hpos = 10'(12 + i);
        vpos = 10'd32;
      end else begin
        idle_pos();
      end
      @(posedge clk);
      #1;
      if (i >= 1) begin
        h       = 12 + i - 1;
        exp_act = (h >= 16 && h <= 47);
        exp_col = BG;
        if (h >= 24 && h <= 31 && a_row0[7 - (h - 24)]) exp_col = FG;
        n_cmp++;
        if ({blue, green, red} !== exp_col || active !== exp_act) begin
          n_err++;
          $display("[TB] FAIL scan_pixel: h %0d got %h/%b want %h/%b",
                   h, {blue, green, red}, active, exp_col, exp_act);
        end
      end
    end
  endtask

  task automatic test_window_write();
    hpos     = 10'd20;
    vpos     = 10'd40;
    wr_addr  = 3'd2;
    wr_data  = 8'h0B;
    wr_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (wr_ready !== 1'b0) begin
        n_err++;
        $display("[TB] FAIL ready_in_window: cycle %0d got %b want 0", k, wr_ready);
      end
    end
    @(posedge clk);
    #1;
    idle_pos();
    @(negedge clk);
    n_cmp++;
    if (wr_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL ready_on_exit: got %b want 1", wr_ready);
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    hpos = 10'd35;
    vpos = 10'd32;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({blue, green, red} !== FG) begin
      n_err++;
      $display("[TB] FAIL cell2_on_pixel: got %h want %h", {blue, green, red}, FG);
    end
    hpos = 10'd32;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({blue, green, red} !== BG) begin
      n_err++;
      $display("[TB] FAIL cell2_off_pixel: got %h want %h", {blue, green, red}, BG);
    end
    idle_pos();
    n_cmp++;
    if (wr_err !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL wr_err_clean: got %b want 0", wr_err);
    end
  endtask

  task automatic test_wr_err();
    e_addr  = 4'd9;
    e_data  = 8'h0B;
    e_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (e_ready !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL err_ready: got %b want 1", e_ready);
    end
    @(posedge clk);
    #1;
    e_valid = 1'b0;
    n_cmp++;
    if (e_err !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL err_set: got %b want 1", e_err);
    end
    repeat (5) @(posedge clk);
    #1;
    e_addr  = 4'd0;
    e_data  = 8'h25;
    e_valid = 1'b1;
    @(posedge clk);
    #1;
    e_valid = 1'b0;
    n_cmp++;
    if (e_err !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL err_sticky: got %b want 1", e_err);
    end
    n_cmp++;
    if (wr_err !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL err_isolated: main wr_err got %b want 0", wr_err);
    end
    hpos = 10'd19;
    vpos = 10'd32;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({e_blue, e_green, e_red} !== BG || e_active !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL err_buf_cell0: got %h/%b want %h/1", {e_blue, e_green, e_red}, e_active, BG);
    end
    idle_pos();
  endtask

  task automatic test_blink();
    logic [23:0] exp_col;
    do_write(3'd1, 8'hCB);
    for (int f = 0; f < 64; f++) begin
      hpos = 10'd27;
      vpos = 10'd32;
      repeat (2) @(posedge clk);
      #1;
      exp_col = (f < 32) ? BG : FG;
      n_cmp++;
      if ({blue, green, red} !== exp_col) begin
        n_err++;
        $display("[TB] FAIL blink_lit_bit: frame %0d got %h want %h", f, {blue, green, red}, exp_col);
      end
      hpos = 10'd24;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({blue, green, red} !== FG) begin
        n_err++;
        $display("[TB] FAIL blink_dark_bit: frame %0d got %h want %h", f, {blue, green, red}, FG);
      end
      hpos = 10'd0;
      vpos = 10'd0;
      @(posedge clk);
      #1;
      idle_pos();
    end
  endtask

  task automatic test_clear_then_reset();
    int cnt;
    clear    = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 3'd3;
    wr_data  = 8'h0B;
    #1;
    n_cmp++;
    if (wr_ready !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL clear_beats_write: ready got %b want 0", wr_ready);
    end
    @(posedge clk);
    #1;
    clear    = 1'b0;
    wr_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL clear_started: busy got %b want 1", busy);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({blue, green, red} !== 24'h0 || active !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL midclear_reset_out: got %h/%b want 000000/0", {blue, green, red}, active);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy !== 1'b1) break;
      cnt++;
      @(negedge clk);
    end
    n_cmp++;
    if (cnt != 8) begin
      n_err++;
      $display("[TB] FAIL clear_restart: busy for %0d cycles, want 8", cnt);
    end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (wr_err !== 1'b0 || e_err !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL err_reset: got %b/%b want 0/0", wr_err, e_err);
    end
    hpos = 10'd27;
    vpos = 10'd32;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({blue, green, red} !== BG) begin
      n_err++;
      $display("[TB] FAIL recleared_cell1: got %h want %h", {blue, green, red}, BG);
    end
    hpos = 10'd43;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({blue, green, red} !== BG) begin
      n_err++;
      $display("[TB] FAIL cell3_not_written: got %h want %h", {blue, green, red}, BG);
    end
    idle_pos();
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    a_row0   = 8'h18;
    reset_n  = 1'b0;
    hpos     = IDLE_H;
    vpos     = IDLE_V;
    clear    = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    e_valid  = 1'b0;
    e_addr   = '0;
    e_data   = '0;

    test_reset();
    test_pixel_scan();
    test_window_write();
    test_wr_err();
    test_blink();
    test_clear_then_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
